// File: rtl/benes_cfg_sched.sv
// Configuration scheduler for the 8-port Benes router: round-robin request arbitration,
// bijection check, router sequencing, and frame-synchronous commit of the 20-bit switch state.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; req_ready grants one requester
// ST_CHECK | validating the latched permutation as a bijection
// ST_ROUTE | rt_mp stable, rt_start pulsed, latency counter loaded
// ST_WAIT  | counting down the router latency, sample rt_state at zero
// ST_PEND  | shadow holds new state, waiting for frame_sync to commit
module benes_cfg_sched #(
    parameter int ROUTE_LAT = 12
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [1:0]  req_valid,
    input  logic [23:0] req_perm0,
    input  logic [23:0] req_perm1,
    output logic [1:0]  req_ready,
    output logic [23:0] rt_mp,
    output logic        rt_start,
    input  logic [19:0] rt_state,
    input  logic        frame_sync,
    output logic [19:0] cfg_active,
    output logic        cfg_owner,
    output logic        cfg_swap,
    output logic        err,
    output logic        err_owner,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ROUTE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_PEND  = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(ROUTE_LAT - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic [23:0] perm_q, perm_d;
    logic [23:0] rt_mp_q, rt_mp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [19:0] shadow_q, shadow_d;
    logic [19:0] cfg_active_q, cfg_active_d;
    logic        cfg_owner_q, cfg_owner_d;
    logic        cfg_swap_q, cfg_swap_d;
    logic        err_q, err_d;
    logic        err_owner_q, err_owner_d;
    logic [1:0]  grant;

    function automatic logic is_bijection(input logic [23:0] p);
        logic [7:0] seen;
        seen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seen[p[3*i +: 3]] = 1'b1;
        end
        return (seen == 8'hFF);
    endfunction

    always_comb begin
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        perm_d       = perm_q;
        rt_mp_d      = rt_mp_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        cfg_active_d = cfg_active_q;
        cfg_owner_d  = cfg_owner_q;
        cfg_swap_d   = 1'b0;
        err_d        = 1'b0;
        err_owner_d  = err_owner_q;
        req_ready    = 2'b00;
        rt_start     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // ready is masked during reset so no grant is advertised while held
                req_ready = areset ? grant : 2'b00;
                if (grant != 2'b00) begin
                    perm_d  = grant[1] ? req_perm1 : req_perm0;
                    gnt_d   = grant[1];
                    ptr_d   = ~grant[1];
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (is_bijection(perm_q)) begin
                    rt_mp_d = perm_q;
                    state_d = ST_ROUTE;
                end else begin
                    err_d       = 1'b1;
                    err_owner_d = gnt_q;
                    state_d     = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                rt_start = 1'b1;
                cnt_d    = CNT_LOAD;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    shadow_d = rt_state;
                    state_d  = ST_PEND;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_PEND: begin
                if (frame_sync) begin
                    cfg_active_d = shadow_q;
                    cfg_owner_d  = gnt_q;
                    cfg_swap_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            gnt_q        <= 1'b0;
            perm_q       <= 24'h0;
            rt_mp_q      <= 24'h0;
            cnt_q        <= 8'h0;
            shadow_q     <= 20'h0;
            cfg_active_q <= 20'h0;
            cfg_owner_q  <= 1'b0;
            cfg_swap_q   <= 1'b0;
            err_q        <= 1'b0;
            err_owner_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            perm_q       <= perm_d;
            rt_mp_q      <= rt_mp_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            cfg_active_q <= cfg_active_d;
            cfg_owner_q  <= cfg_owner_d;
            cfg_swap_q   <= cfg_swap_d;
            err_q        <= err_d;
            err_owner_q  <= err_owner_d;
        end
    end

    assign rt_mp      = rt_mp_q;
    assign cfg_active = cfg_active_q;
    assign cfg_owner  = cfg_owner_q;
    assign cfg_swap   = cfg_swap_q;
    assign err        = err_q;
    assign err_owner  = err_owner_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_benes_cfg_sched.sv
// Bench for benes_cfg_sched: directed scenarios with literal expectations plus a
// timeline-based reference model checked against the DUT every cycle.
module tb_benes_cfg_sched;

    localparam int L   = 12;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        areset;
    logic [1:0]  req_valid;
    logic [23:0] req_perm0, req_perm1;
    logic [1:0]  req_ready;
    logic [23:0] rt_mp;
    logic        rt_start;
    logic [19:0] rt_state;
    logic        frame_sync;
    logic [19:0] cfg_active;
    logic        cfg_owner, cfg_swap, err, err_owner, busy;

    always #5 clk = ~clk;

    benes_cfg_sched #(.ROUTE_LAT(L)) dut (
        .clk(clk), .areset(areset), .req_valid(req_valid),
        .req_perm0(req_perm0), .req_perm1(req_perm1), .req_ready(req_ready),
        .rt_mp(rt_mp), .rt_start(rt_start), .rt_state(rt_state),
        .frame_sync(frame_sync), .cfg_active(cfg_active), .cfg_owner(cfg_owner),
        .cfg_swap(cfg_swap), .err(err), .err_owner(err_owner), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] f_grant(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    function automatic bit f_is_perm(input logic [23:0] p);
        bit found;
        for (int v = 0; v < 8; v++) begin
            found = 1'b0;
            for (int i = 0; i < 8; i++)
                if (p[3*i +: 3] == v[2:0]) found = 1'b1;
            if (!found) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [23:0] f_pack(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [23:0] f_rand_perm();
        int a[8];
        int j, t;
        logic [23:0] r;
        for (int i = 0; i < 8; i++) a[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = a[i]; a[i] = a[j]; a[j] = t;
        end
        r = 24'h0;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(a[i]);
        return r;
    endfunction

    // Reference model: each accepted request schedules its visible events by cycle number.
    int          cyc = 0;
    int          free_at, start_at, err_at, swap_at, sample_at, pend_from, mc;
    bit          pending;
    logic        ptr_m, t_gnt, owner_m, eo_m;
    logic [23:0] t_perm, mp_m;
    logic [19:0] shadow_m, cfg_m;
    logic [1:0]  acc_mask, mg;

    initial forever begin
        @(posedge clk);
        mc = cyc;
        acc_mask = 2'b00;
        if (!areset) begin
            free_at = 0; start_at = -1; err_at = -1; swap_at = -1; sample_at = -1;
            pend_from = BIG; pending = 1'b0;
            ptr_m = 1'b0; t_gnt = 1'b0; owner_m = 1'b0; eo_m = 1'b0;
            t_perm = 24'h0; mp_m = 24'h0; shadow_m = 20'h0; cfg_m = 20'h0;
        end else begin
            if (pending && mc >= pend_from && frame_sync) begin
                cfg_m = shadow_m; owner_m = t_gnt; swap_at = mc + 1; free_at = mc + 1;
                pending = 1'b0; pend_from = BIG;
            end
            if (mc == sample_at) shadow_m = rt_state;
            if (mc >= free_at) begin
                mg = f_grant(req_valid, ptr_m);
                if (mg != 2'b00) begin
                    acc_mask = mg;
                    t_gnt    = mg[1];
                    t_perm   = mg[1] ? req_perm1 : req_perm0;
                    ptr_m    = ~mg[1];
                    if (f_is_perm(t_perm)) begin
                        start_at = mc + 2; sample_at = mc + 2 + L; pend_from = mc + 3 + L;
                        pending = 1'b1; free_at = BIG;
                    end else begin
                        err_at = mc + 2; free_at = mc + 2;
                    end
                end
            end
            if (mc + 1 == start_at) mp_m = t_perm;
            if (mc + 1 == err_at)   eo_m = t_gnt;
        end
        cyc = mc + 1;
    end

    logic [1:0] e_ready;
    bit         in_rst;

    initial forever begin
        @(negedge clk);
        in_rst  = !areset;
        e_ready = (in_rst || cyc < free_at) ? 2'b00 : f_grant(req_valid, ptr_m);
        chk("m_req_ready",  32'(req_ready),  32'(e_ready));
        chk("m_rt_start",   32'(rt_start),   in_rst ? 0 : 32'(cyc == start_at));
        chk("m_err",        32'(err),        in_rst ? 0 : 32'(cyc == err_at));
        chk("m_cfg_swap",   32'(cfg_swap),   in_rst ? 0 : 32'(cyc == swap_at));
        chk("m_busy",       32'(busy),       in_rst ? 0 : 32'(cyc < free_at));
        chk("m_rt_mp",      32'(rt_mp),      in_rst ? 0 : 32'(mp_m));
        chk("m_cfg_active", 32'(cfg_active), in_rst ? 0 : 32'(cfg_m));
        chk("m_cfg_owner",  32'(cfg_owner),  in_rst ? 0 : 32'(owner_m));
        chk("m_err_owner",  32'(err_owner),  in_rst ? 0 : 32'(eo_m));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 60; k++) begin
            #1;
            if (!busy) break;
            step();
        end
        chk(name, 32'(busy), 0);
    endtask

    logic [23:0] P, Q, R;
    int          gr[3];
    int          ngr;
    bit          nxt;

    initial begin
        areset = 1'b0; req_valid = 2'b11; rt_state = 20'h0; frame_sync = 1'b0;
        req_perm0 = f_rand_perm(); req_perm1 = f_rand_perm();
        P = f_pack(0, 1, 4, 5, 7, 6, 3, 2);
        Q = f_pack(7, 6, 5, 4, 3, 2, 1, 0);
        R = f_pack(3, 2, 1, 0, 7, 6, 5, 4);

        // reset with both requesters valid
        repeat (5) step();
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_active", 32'(cfg_active), 0);
        chk("rst_rt_mp", 32'(rt_mp), 0);

        // arbitration: both valid continuously, immediate frame_sync
        step();
        areset = 1'b1; frame_sync = 1'b1; rt_state = 20'h11111;
        ngr = 0; nxt = 1'b0;
        for (int k = 0; k < 9; k++) gr[k % 3] = 9;
        for (int k = 0; k < 80 && ngr < 3; k++) begin
            #1;
            if (nxt) chk("arb_ready_width", 32'(req_ready), 0);
            nxt = (req_ready != 2'b00);
            if (nxt) begin
                gr[ngr] = int'(req_ready[1]);
                ngr++;
            end
            step();
        end
        req_valid = 2'b00;
        #1;
        chk("arb_ready_width", 32'(req_ready), 0);
        chk("arb_count", ngr, 3);
        chk("arb_order0", gr[0], 0);
        chk("arb_order1", gr[1], 1);
        chk("arb_order2", gr[2], 0);
        wait_idle("arb_idle_timeout");
        frame_sync = 1'b0;
        chk("arb_cfg", 32'(cfg_active), 32'h11111);

        // single request from requester 0
        step();
        rt_state = 20'hA5A5A; req_valid = 2'b01; req_perm0 = P;
        #1 chk("single_accept_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        step();
        #1;
        chk("single_rt_start", 32'(rt_start), 1);
        chk("single_rt_mp", 32'(rt_mp), 32'(P));
        repeat (13) step();
        #1;
        chk("single_shadow", 32'(dut.shadow_q), 32'hA5A5A);
        chk("single_pend_busy", 32'(busy), 1);
        chk("single_cfg_hold", 32'(cfg_active), 32'h11111);
        rt_state = 20'h0;
        repeat (5) step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        #1;
        chk("single_swap", 32'(cfg_swap), 1);
        chk("single_cfg", 32'(cfg_active), 32'hA5A5A);
        chk("single_owner", 32'(cfg_owner), 0);
        step();
        #1 chk("single_swap_width", 32'(cfg_swap), 0);

        // non-bijective request from requester 1
        step();
        req_valid = 2'b10; req_perm1 = f_pack(0, 0, 2, 3, 4, 5, 6, 7);
        #1 chk("inv_accept_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00;
        #1 chk("inv_no_start_check", 32'(rt_start), 0);
        step();
        #1;
        chk("inv_err", 32'(err), 1);
        chk("inv_err_owner", 32'(err_owner), 1);
        chk("inv_no_start", 32'(rt_start), 0);
        chk("inv_cfg_kept", 32'(cfg_active), 32'hA5A5A);
        chk("inv_mp_kept", 32'(rt_mp), 32'(P));
        step();
        #1;
        chk("inv_err_width", 32'(err), 0);
        chk("inv_no_start_late", 32'(rt_start), 0);

        // follow-up valid request from requester 0 completes
        step();
        req_valid = 2'b01; req_perm0 = Q; rt_state = 20'h12345; frame_sync = 1'b1;
        #1 chk("recover_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        wait_idle("recover_idle_timeout");
        frame_sync = 1'b0;
        chk("recover_cfg", 32'(cfg_active), 32'h12345);
        chk("recover_owner", 32'(cfg_owner), 0);
        chk("recover_mp", 32'(rt_mp), 32'(Q));

        // frame_sync during CHECK and WAIT is ignored
        step();
        req_valid = 2'b10; req_perm1 = R; rt_state = 20'h0F0F0;
        #1 chk("fs_accept_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00; frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        repeat (3) step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1 chk("fs_no_early_swap", 32'(cfg_swap), 0);
            step();
        end
        #1;
        chk("fs_pend_busy", 32'(busy), 1);
        chk("fs_cfg_hold", 32'(cfg_active), 32'h12345);
        step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        #1;
        chk("fs_swap", 32'(cfg_swap), 1);
        chk("fs_cfg", 32'(cfg_active), 32'h0F0F0);
        chk("fs_owner", 32'(cfg_owner), 1);
        step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        #1 chk("fs_idle_no_swap", 32'(cfg_swap), 0);
        step();
        #1;
        chk("fs_idle_no_swap2", 32'(cfg_swap), 0);
        chk("fs_cfg_kept", 32'(cfg_active), 32'h0F0F0);

        // reset in the middle of WAIT
        step();
        req_valid = 2'b01; req_perm0 = P; rt_state = 20'h33333;
        step();
        req_valid = 2'b00;
        repeat (8) step();
        #1 chk("mid_cnt", 32'(dut.cnt_q), 5);
        areset = 1'b0;
        #1;
        chk("mid_rt_mp", 32'(rt_mp), 0);
        chk("mid_cfg", 32'(cfg_active), 0);
        chk("mid_owner", 32'(cfg_owner), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_err_owner", 32'(err_owner), 0);
        step();
        areset = 1'b1;
        for (int k = 0; k < 24; k++) begin
            frame_sync = (k % 3 == 0);
            #1;
            chk("mid_no_swap", 32'(cfg_swap), 0);
            chk("mid_cfg_zero", 32'(cfg_active), 0);
            step();
        end
        frame_sync = 1'b0;

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step();
            for (int r = 0; r < 2; r++) begin
                if (acc_mask[r]) req_valid[r] = 1'b0;
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    req_valid[r] = 1'b1;
                    if (r == 0) req_perm0 = ($urandom_range(0, 3) == 0) ? 24'($urandom) : f_rand_perm();
                    else        req_perm1 = ($urandom_range(0, 3) == 0) ? 24'($urandom) : f_rand_perm();
                end
            end
            rt_state   = 20'($urandom);
            frame_sync = ($urandom_range(0, 3) == 0);
            if (!areset) areset = 1'b1;
            else if ($urandom_range(0, 499) == 0) areset = 1'b0;
        end
        step();
        req_valid = 2'b00; frame_sync = 1'b0; areset = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
